// File: rtl/hp_serial_ctrl.sv
// hp_serial_ctrl: bus-programmable byte FIFO feeding a serial shifter for
// cascaded dot-matrix display chips (HP_CLK / HP_DO / per-chip CE).
// Build option: define HP_SERIAL_IRQ_EN to include the burst-done interrupt
// (IRQ output, CTRL.IRQ_EN bit, STATUS write-to-clear). Without it IRQ is 0.
module hp_serial_ctrl #(
    parameter int DIV_W      = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int N_CHIPS    = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               WE,
    input  logic [3:0]         A,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic [N_CHIPS-1:0] HP_CE_N,
    output logic               HP_RS,
    output logic               HP_RESET_N,
    output logic               HP_BLANK,
    output logic               HP_DO,
    output logic               HP_CLK,
    output logic               IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t             state;
    logic               ctrl_rs;
    logic               ctrl_blank;
    logic               ctrl_drst;
    logic               ctrl_irq_en;
    logic [3:0]         ctrl_csel;
    logic               ovf;
    logic               irq;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               busy;
    logic               wr_ctrl;
    logic               wr_stat;

    logic [DIV_W-1:0]   div_cnt;
    logic               half_tick;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               hp_clk_q;
    logic               rs_q;
    logic [N_CHIPS-1:0] ce_n_q;
    logic [N_CHIPS-1:0] ce_sel_n;
    logic               unused_wd;

    assign wr_ctrl   = WE && (A == 4'd1);
    assign wr_stat   = WE && (A == 4'd2);
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = WE && (A == 4'd0) && !full;
    assign half_tick = &div_cnt;
    assign busy      = (state != IDLE) || !empty;
    assign unused_wd = ^WD[31:12];

    // A byte leaves the FIFO when the shifter is idle, or at the last falling edge of a byte to chain the next one
    assign pop = !empty && ((state == IDLE) ||
                 ((state == SHIFT) && half_tick && hp_clk_q && (bit_cnt == 3'd7)));

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (WE && (A == 4'd0) && full)
                ovf <= 1'b1;
            else if (wr_stat && WD[3])
                ovf <= 1'b0;
        end
    end

    // FIFO storage needs no reset; only the pointers define its contents
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= WD[7:0];
    end

    // CTRL register fields that exist in every build
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_rs    <= 1'b0;
            ctrl_blank <= 1'b0;
            ctrl_drst  <= 1'b1;
            ctrl_csel  <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl_rs    <= WD[1];
            ctrl_blank <= WD[2];
            ctrl_drst  <= WD[4];
            ctrl_csel  <= WD[11:8];
        end
    end

`ifdef HP_SERIAL_IRQ_EN
    logic burst_done;
    assign burst_done = (state == HOLD) && half_tick;

    // Interrupt enable and level interrupt; a completion in the same cycle as a clear keeps it set
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl_irq_en <= WD[5];
            if (burst_done && ctrl_irq_en)
                irq <= 1'b1;
            else if (wr_stat && WD[0])
                irq <= 1'b0;
        end
    end
`else
    assign ctrl_irq_en = 1'b0;
    assign irq         = 1'b0;
`endif

    // Decode CTRL.CSEL into active-low enables; out-of-range selects enable nothing
    always_comb begin
        ce_sel_n = '1;
        for (int i = 0; i < N_CHIPS; i++) begin
            if (ctrl_csel == 4'(i))
                ce_sel_n[i] = 1'b0;
        end
    end

    // Serial engine: SETUP half-period, 16 clock half-periods per byte, one HOLD half-period
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            hp_clk_q <= 1'b0;
            rs_q     <= 1'b0;
            ce_n_q   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    hp_clk_q <= 1'b0;
                    ce_n_q   <= '1;
                    if (!empty) begin
                        shreg   <= mem[rd_ptr];
                        rs_q    <= ctrl_rs;
                        ce_n_q  <= ce_sel_n;
                        div_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    div_cnt <= div_cnt + DIV_W'(1);
                    if (half_tick)
                        state <= SHIFT;
                end
                SHIFT: begin
                    div_cnt <= div_cnt + DIV_W'(1);
                    if (half_tick) begin
                        if (!hp_clk_q) begin
                            hp_clk_q <= 1'b1;
                        end else begin
                            hp_clk_q <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (!empty) begin
                                    shreg <= mem[rd_ptr];
                                end else begin
                                    shreg <= {shreg[6:0], 1'b0};
                                    state <= HOLD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    div_cnt <= div_cnt + DIV_W'(1);
                    if (half_tick) begin
                        ce_n_q <= '1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register read mux, combinational on the address
    always_comb begin
        RD = '0;
        case (A)
            4'd1: begin
                RD[1]    = ctrl_rs;
                RD[2]    = ctrl_blank;
                RD[4]    = ctrl_drst;
                RD[5]    = ctrl_irq_en;
                RD[11:8] = ctrl_csel;
            end
            4'd2: begin
                RD[0]     = busy;
                RD[1]     = empty;
                RD[2]     = full;
                RD[3]     = ovf;
                RD[15:8]  = 8'(count);
            end
            default: RD = '0;
        endcase
    end

    assign HP_CE_N    = ce_n_q;
    assign HP_RS      = rs_q;
    assign HP_RESET_N = ~ctrl_drst;
    assign HP_BLANK   = ctrl_blank;
    assign HP_DO      = shreg[7];
    assign HP_CLK     = hp_clk_q;
    assign IRQ        = irq;

endmodule

// File: tb/tb_hp_serial_ctrl.sv
// Testbench for hp_serial_ctrl: directed scenarios plus random traffic,
// every cycle compared against a transaction/timeline model of the display link.
module tb_hp_serial_ctrl;

    localparam int DIV_W      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int N_CHIPS    = 4;
    localparam int H          = 1 << DIV_W;

`ifdef HP_SERIAL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RESET;
    logic               WE;
    logic [3:0]         A;
    logic [31:0]        WD;
    logic [31:0]        RD;
    logic [N_CHIPS-1:0] HP_CE_N;
    logic               HP_RS;
    logic               HP_RESET_N;
    logic               HP_BLANK;
    logic               HP_DO;
    logic               HP_CLK;
    logic               IRQ;

    always #5 CLK = ~CLK;

    hp_serial_ctrl #(
        .DIV_W     (DIV_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .N_CHIPS   (N_CHIPS)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .WE        (WE),
        .A         (A),
        .WD        (WD),
        .RD        (RD),
        .HP_CE_N   (HP_CE_N),
        .HP_RS     (HP_RS),
        .HP_RESET_N(HP_RESET_N),
        .HP_BLANK  (HP_BLANK),
        .HP_DO     (HP_DO),
        .HP_CLK    (HP_CLK),
        .IRQ       (IRQ)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model: FIFO as a queue, burst as a timeline measured in CLK cycles
    logic [7:0] m_q[$];
    logic [7:0] m_burst[$];
    bit         m_active;
    int         m_t;
    int         m_end_t;
    bit         m_ovf, m_irq;
    bit         m_rs, m_blank, m_drst, m_irq_en;
    bit [3:0]   m_csel;
    bit         m_rs_lat;
    bit [3:0]   m_csel_lat;

    // Observation of the serial link
    bit         prev_hpclk, prev_ce_all, prev_irq;
    int         rise_cnt, last_rise, gap_min, gap_max, ce_falls, ce_rise_cyc, irq_rise_cyc;
    logic [31:0] rise_bits;
    bit         ce1_seen;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelEdge(input bit rst, input bit we, input logic [3:0] a, input logic [31:0] wd);
        bit pop_idle, pop_b2b, going_idle, push_req, was_full, irq_set, irq_clr;
        logic [7:0] popped;
        if (rst) begin
            m_q.delete();
            m_burst.delete();
            m_active = 0; m_t = 0; m_end_t = 0;
            m_ovf = 0; m_irq = 0;
            m_rs = 0; m_blank = 0; m_drst = 1; m_irq_en = 0; m_csel = 0;
            m_rs_lat = 0; m_csel_lat = 0;
            return;
        end
        pop_idle   = !m_active && (m_q.size() != 0);
        pop_b2b    = m_active && (m_t + 1 == m_end_t - H) && (m_q.size() != 0);
        going_idle = m_active && (m_t + 1 == m_end_t);
        push_req   = we && (a == 4'd0);
        was_full   = (m_q.size() == FIFO_DEPTH);
        irq_set    = going_idle && m_irq_en;
        irq_clr    = we && (a == 4'd2) && wd[0];
        popped     = 8'd0;
        if (pop_idle || pop_b2b)
            popped = m_q.pop_front();
        if (push_req && !was_full)
            m_q.push_back(wd[7:0]);
        if (pop_idle) begin
            m_active   = 1;
            m_t        = 0;
            m_end_t    = 18 * H;
            m_burst.delete();
            m_burst.push_back(popped);
            m_rs_lat   = m_rs;
            m_csel_lat = m_csel;
        end else if (m_active) begin
            m_t++;
            if (pop_b2b) begin
                m_end_t += 16 * H;
                m_burst.push_back(popped);
            end
            if (m_t == m_end_t)
                m_active = 0;
        end
        if (we && (a == 4'd2) && wd[3])
            m_ovf = 0;
        if (push_req && was_full)
            m_ovf = 1;
        m_irq = IRQ_ON && ((m_irq && !irq_clr) || irq_set);
        if (we && (a == 4'd1)) begin
            m_rs     = wd[1];
            m_blank  = wd[2];
            m_drst   = wd[4];
            m_irq_en = IRQ_ON && wd[5];
            m_csel   = wd[11:8];
        end
    endtask

    function automatic logic [3:0] expCe();
        logic [3:0] c;
        c = 4'hF;
        if (m_active && (m_csel_lat < N_CHIPS))
            c[m_csel_lat[1:0]] = 1'b0;
        return c;
    endfunction

    function automatic logic expHpClk();
        if (!m_active || (m_t < H) || (m_t >= m_end_t - H))
            return 1'b0;
        return (((m_t - H) / H) % 2) == 1;
    endfunction

    function automatic logic expDo();
        int s, bi, bidx;
        logic [7:0] b;
        if (!m_active || (m_t >= m_end_t - H))
            return 1'b0;
        s    = (m_t < H) ? 0 : (m_t - H);
        bi   = s / (16 * H);
        bidx = (s % (16 * H)) / (2 * H);
        b    = m_burst[bi];
        return b[7 - bidx];
    endfunction

    function automatic logic [31:0] expRd(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 4'd1) begin
            r[1] = m_rs; r[2] = m_blank; r[4] = m_drst; r[5] = m_irq_en; r[11:8] = m_csel;
        end else if (a == 4'd2) begin
            r[0]     = m_active || (m_q.size() != 0);
            r[1]     = (m_q.size() == 0);
            r[2]     = (m_q.size() == FIFO_DEPTH);
            r[3]     = m_ovf;
            r[15:8]  = 8'(m_q.size());
        end
        return r;
    endfunction

    task automatic monitorClear();
        rise_cnt = 0; last_rise = -1; gap_min = 1000; gap_max = 0;
        ce_falls = 0; ce_rise_cyc = -1; irq_rise_cyc = -1; rise_bits = '0; ce1_seen = 0;
    endtask

    task automatic monitorSample();
        if (!prev_hpclk && HP_CLK) begin
            rise_cnt++;
            rise_bits = {rise_bits[30:0], HP_DO};
            if (last_rise >= 0) begin
                if (cyc - last_rise < gap_min) gap_min = cyc - last_rise;
                if (cyc - last_rise > gap_max) gap_max = cyc - last_rise;
            end
            last_rise = cyc;
        end
        if (prev_ce_all && (HP_CE_N != 4'hF)) ce_falls++;
        if (!prev_ce_all && (HP_CE_N == 4'hF)) ce_rise_cyc = cyc;
        if (!prev_irq && IRQ) irq_rise_cyc = cyc;
        if (HP_CE_N == 4'b1101) ce1_seen = 1;
        prev_hpclk  = HP_CLK;
        prev_ce_all = (HP_CE_N == 4'hF);
        prev_irq    = IRQ;
    endtask

    // One CLK cycle: drive on the falling edge, advance the model, check after the rising edge
    task automatic applyStimulus(input bit rst, input bit we, input logic [3:0] a, input logic [31:0] wd);
        @(negedge CLK);
        RESET = rst; WE = we; A = a; WD = wd;
        modelEdge(rst, we, a, wd);
        @(posedge CLK);
        #1;
        cyc++;
        checkOutput("ce_n",    32'(HP_CE_N),    32'(expCe()));
        checkOutput("hp_clk",  32'(HP_CLK),     32'(expHpClk()));
        checkOutput("hp_do",   32'(HP_DO),      32'(expDo()));
        checkOutput("hp_rs",   32'(HP_RS),      32'(m_rs_lat));
        checkOutput("reset_n", 32'(HP_RESET_N), 32'(!m_drst));
        checkOutput("blank",   32'(HP_BLANK),   32'(m_blank));
        checkOutput("irq",     32'(IRQ),        32'(m_irq));
        checkOutput("rd",      RD,              expRd(a));
        monitorSample();
    endtask

    initial begin
        int push_cyc;
        logic [7:0] b0, b1, b2;
        RESET = 1'b1; WE = 1'b0; A = 4'd0; WD = '0;
        prev_hpclk = 0; prev_ce_all = 1; prev_irq = 0;
        monitorClear();

        // Reset values
        applyStimulus(1, 0, 4'd2, 0);
        applyStimulus(1, 0, 4'd2, 0);
        applyStimulus(0, 0, 4'd1, 0);
        checkOutput("rst_ctrl", RD, 32'h10);
        applyStimulus(0, 0, 4'd2, 0);
        checkOutput("rst_status", RD, 32'h2);
        checkOutput("rst_resetn", 32'(HP_RESET_N), 0);
        checkOutput("rst_ce", 32'(HP_CE_N), 32'hF);

        // Single byte 0xA5 to chip 1
        monitorClear();
        applyStimulus(0, 1, 4'd1, 32'h100);
        applyStimulus(0, 1, 4'd0, 32'hA5);
        push_cyc = cyc;
        repeat (90) applyStimulus(0, 0, 4'd2, 0);
        checkOutput("a5_bits", 32'(rise_bits[7:0]), 32'hA5);
        checkOutput("a5_rises", rise_cnt, 8);
        checkOutput("a5_gap_min", gap_min, 8);
        checkOutput("a5_gap_max", gap_max, 8);
        checkOutput("a5_ce1_low", 32'(ce1_seen), 1);
        checkOutput("a5_ce_release", ce_rise_cyc - push_cyc, 1 + 18 * H);
        checkOutput("a5_busy", 32'(RD[0]), 0);

        // Three bytes back to back: one CE window, 24 clock pulses
        monitorClear();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        applyStimulus(0, 1, 4'd1, 32'h202);
        applyStimulus(0, 1, 4'd0, 32'(b0));
        push_cyc = cyc;
        applyStimulus(0, 1, 4'd0, 32'(b1));
        applyStimulus(0, 1, 4'd0, 32'(b2));
        repeat (240) applyStimulus(0, 0, 4'd2, 0);
        checkOutput("b2b_ce_windows", ce_falls, 1);
        checkOutput("b2b_rises", rise_cnt, 24);
        checkOutput("b2b_bits", 32'(rise_bits[23:0]), 32'({b0, b1, b2}));
        checkOutput("b2b_gap_max", gap_max, 8);
        checkOutput("b2b_ce_release", ce_rise_cyc - push_cyc, 1 + H * (2 + 16 * 3));

        // Overflow of a 4-deep FIFO
        applyStimulus(1, 0, 4'd2, 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 4'd0, 32'($urandom));
        applyStimulus(0, 0, 4'd2, 0);
        checkOutput("ovf_set", 32'(RD[3]), 1);
        checkOutput("ovf_full", 32'(RD[2]), 1);
        checkOutput("ovf_count", 32'(RD[15:8]), 4);
        applyStimulus(0, 1, 4'd2, 32'h8);
        checkOutput("ovf_clear", 32'(RD[3]), 0);
        repeat (360) applyStimulus(0, 0, 4'd2, 0);

        // Interrupt on burst completion, then reset in the middle of a bit
        monitorClear();
        applyStimulus(0, 1, 4'd1, 32'h320);
        applyStimulus(0, 0, 4'd1, 0);
        checkOutput("ctrl_readback", RD, IRQ_ON ? 32'h320 : 32'h300);
        applyStimulus(0, 1, 4'd0, 32'h3C);
        push_cyc = cyc;
        repeat (80) applyStimulus(0, 0, 4'd2, 0);
        checkOutput("irq_rise_cyc", irq_rise_cyc, IRQ_ON ? (push_cyc + 1 + 18 * H) : -1);
        checkOutput("irq_level", 32'(IRQ), 32'(IRQ_ON));
        applyStimulus(0, 1, 4'd2, 32'h1);
        checkOutput("irq_clear", 32'(IRQ), 0);
        applyStimulus(0, 1, 4'd0, 32'h81);
        repeat (26) applyStimulus(0, 0, 4'd2, 0);
        checkOutput("midbit_hpclk_high", 32'(HP_CLK), 1);
        applyStimulus(1, 0, 4'd2, 0);
        checkOutput("midrst_hpclk", 32'(HP_CLK), 0);
        checkOutput("midrst_ce", 32'(HP_CE_N), 32'hF);
        checkOutput("midrst_count", 32'(RD[15:8]), 0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0)
                applyStimulus(1, 0, 4'd2, 0);
            else if (r < 5)
                applyStimulus(0, 1, 4'd0, $urandom);
            else if (r < 7)
                applyStimulus(0, 1, 4'd1, $urandom);
            else if (r < 9)
                applyStimulus(0, 1, 4'd2, $urandom);
            else if (r < 10)
                applyStimulus(0, 1, 4'($urandom_range(3, 15)), $urandom);
            else
                applyStimulus(0, 0, 4'($urandom_range(0, 15)), $urandom);
        end
        repeat (100) applyStimulus(0, 0, 4'd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
